// File: rtl/ex_div.sv
// Multi-cycle restoring radix-2 divider for the EX stage; DIV/DIVU with sign correction.
// Result is {remainder, quotient}; divide-by-zero returns zero after a short two-edge path.
module ex_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 cpu_clk_75M,
    input  logic                 cpu_rst_n,
    input  logic                 start_i,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH:0]   shifted;
    logic             take;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    // One restoring step; dvd doubles as the quotient shift register.
    always_comb begin
        shifted = {rem, dvd[WIDTH-1]};
        take    = (shifted >= {1'b0, dvs});
        rem_nxt = take ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
        quo_nxt = {dvd[WIDTH-2:0], take};
        res_q   = neg_q ? (WIDTH'(0) - quo_nxt) : quo_nxt;
        res_r   = neg_r ? (WIDTH'(0) - rem_nxt) : rem_nxt;
        abs_a   = (signed_div_i && opdata1_i[WIDTH-1]) ? (WIDTH'(0) - opdata1_i) : opdata1_i;
        abs_b   = (signed_div_i && opdata2_i[WIDTH-1]) ? (WIDTH'(0) - opdata2_i) : opdata2_i;
    end

    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state    <= FREE;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    if (start_i && !annul_i) begin
                        dvd    <= abs_a;
                        dvs    <= abs_b;
                        rem    <= '0;
                        cnt    <= '0;
                        neg_q  <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_r  <= signed_div_i && opdata1_i[WIDTH-1];
                        busy_o <= 1'b1;
                        state  <= (opdata2_i == '0) ? BYZERO : ON;
                    end
                end
                BYZERO: begin
                    busy_o   <= 1'b0;
                    result_o <= '0;
                    if (annul_i) begin
                        ready_o <= 1'b0;
                        state   <= FREE;
                    end else begin
                        ready_o <= 1'b1;
                        state   <= END;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        busy_o   <= 1'b0;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                        state    <= FREE;
                    end else begin
                        rem <= rem_nxt;
                        dvd <= quo_nxt;
                        cnt <= cnt + CW'(1);
                        // Last step: publish the sign-corrected result directly.
                        if (cnt == CW'(WIDTH - 1)) begin
                            result_o <= {res_r, res_q};
                            ready_o  <= 1'b1;
                            busy_o   <= 1'b0;
                            state    <= END;
                        end
                    end
                end
                END: begin
                    if (annul_i || !start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                        busy_o   <= 1'b0;
                        state    <= FREE;
                    end
                end
                default: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    busy_o   <= 1'b0;
                    state    <= FREE;
                end
            endcase
        end
    end

endmodule
